// File: rtl/eight_comparator_bcs.sv
// eight_comparator_bcs: 8-bit unsigned magnitude comparator with registered flags.
//
// The compare is a ripple chain of eight identical bit slices. It runs from
// index 0 (the MSB, because operands are numbered big-endian) down to index 7
// (the LSB). The final slice result is registered, so the flags appear
// one cycle after a/b are sampled.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous, active-high reset (flags -> e=1, l=0, as for a=b=0)
//   a    in   [0:7] operand A, unsigned, a[0] is the MSB
//   b    in   [0:7] operand B, unsigned, b[0] is the MSB
//   e    out  registered a == b
//   l    out  registered a <  b
//   g    out  registered a >  b (only when EIGHT_CMP_GT_EN is defined)
//
// Build option:
//   EIGHT_CMP_GT_EN  adds the registered greater-than flag g (resets to 0).
module eight_comparator_bcs (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:7] a,
  input  logic [0:7] b,
  output logic       e,
  output logic       l
`ifdef EIGHT_CMP_GT_EN
  ,
  output logic       g
`endif
);

  logic eq7;
  logic lt7;
  logic e_q, e_d;
  logic l_q, l_d;

  // Ripple through the slices MSB first. Once a slice sees a difference, eq
  // drops and every lower slice is masked. So only the most significant
  // differing bit can set lt. A running pair of variables avoids a
  // self-referencing chain vector.
  always_comb begin
    logic eq_run;
    logic lt_run;
    eq_run = 1'b1;
    lt_run = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      // lt must use the incoming eq, so update it before eq.
      lt_run = lt_run | (eq_run & ~a[i] & b[i]);
      eq_run = eq_run & ~(a[i] ^ b[i]);
    end
    eq7 = eq_run;
    lt7 = lt_run;
  end

  always_comb begin
    e_d = eq7;
    l_d = lt7;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= 1'b1;
      l_q <= 1'b0;
    end else begin
      e_q <= e_d;
      l_q <= l_d;
    end
  end

  assign e = e_q;
  assign l = l_q;

`ifdef EIGHT_CMP_GT_EN
  logic g_q, g_d;

  always_comb begin
    g_d = ~eq7 & ~lt7;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q <= 1'b0;
    end else begin
      g_q <= g_d;
    end
  end

  assign g = g_q;
`endif

endmodule

// File: tb/tb_eight_comparator_bcs.sv
// Directed plus exhaustive self-checking bench for eight_comparator_bcs.
module tb_eight_comparator_bcs;

  logic       clk;
  logic       rst;
  logic [0:7] a;
  logic [0:7] b;
  logic       e;
  logic       l;
`ifdef EIGHT_CMP_GT_EN
  logic       g;
`endif

  int n_checks;
  int n_errors;

  eight_comparator_bcs dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .e   (e),
    .l   (l)
`ifdef EIGHT_CMP_GT_EN
    ,
    .g   (g)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (a=%02h b=%02h t=%0t)", tag, act, exp, a, b, $time);
    end
  endtask

  // Drive operands on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic step(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    @(posedge clk);
    #1;
  endtask

  // Checks the flags for a given hand-computed outcome (gt is implied by e=0, l=0).
  task automatic expect_flags(input string tag, input logic exp_e, input logic exp_l);
    check({tag, ".e"}, e, exp_e);
    check({tag, ".l"}, l, exp_l);
`ifdef EIGHT_CMP_GT_EN
    check({tag, ".g"}, g, ~exp_e & ~exp_l);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    a   = 8'hA5;
    b   = 8'h00;

    // Reset holds the a=b=0 flags for two edges even though a > b.
    @(posedge clk); #1;
    expect_flags("rst_edge1", 1'b1, 1'b0);
    @(posedge clk); #1;
    expect_flags("rst_edge2", 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    expect_flags("post_rst", 1'b0, 1'b0);

    // MSB cases
    step(8'h80, 8'h00); expect_flags("msb_gt", 1'b0, 1'b0);
    step(8'h80, 8'h80); expect_flags("msb_eq", 1'b1, 1'b0);
    step(8'h00, 8'h80); expect_flags("msb_lt", 1'b0, 1'b1);

    // Lower bits must not override the most significant difference
    step(8'hF0, 8'hB0); expect_flags("dom_gt", 1'b0, 1'b0);
    step(8'h70, 8'hFF); expect_flags("dom_lt", 1'b0, 1'b1);
    step(8'hFF, 8'hFF); expect_flags("dom_eq", 1'b1, 1'b0);

    // LSB-only difference
    step(8'hFF, 8'hFE); expect_flags("lsb_gt", 1'b0, 1'b0);
    step(8'h7E, 8'h7F); expect_flags("lsb_lt", 1'b0, 1'b1);

    // Boundaries
    step(8'h00, 8'h00); expect_flags("bnd_zero", 1'b1, 1'b0);
    step(8'h00, 8'hFF); expect_flags("bnd_lt", 1'b0, 1'b1);
    step(8'hFF, 8'h00); expect_flags("bnd_gt", 1'b0, 1'b0);

    // Latency: mid-cycle operand changes must not show until the next edge
    step(8'h12, 8'h34); expect_flags("lat_base", 1'b0, 1'b1);
    @(negedge clk);
    a = 8'h34;
    b = 8'h12;
    #1;
    expect_flags("lat_hold1", 1'b0, 1'b1);
    a = 8'h55;
    b = 8'h55;
    #2;
    expect_flags("lat_hold2", 1'b0, 1'b1);
    @(posedge clk); #1;
    expect_flags("lat_new", 1'b1, 1'b0);

    // Mid-stream reset overrides a less-than compare, then compares resume
    @(negedge clk);
    a   = 8'h01;
    b   = 8'h02;
    rst = 1'b1;
    @(posedge clk); #1;
    expect_flags("rst_mid", 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    expect_flags("rst_resume", 1'b0, 1'b1);

    // Exhaustive sweep against an integer reference model
    for (int i = 0; i < 65536; i++) begin
      logic [7:0] av;
      logic [7:0] bv;
      av = i[15:8];
      bv = i[7:0];
      step(av, bv);
      check("exh.e", e, av == bv);
      check("exh.l", l, av < bv);
      check("exh.not_both", e & l, 1'b0);
`ifdef EIGHT_CMP_GT_EN
      check("exh.g", g, av > bv);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
